// File: rtl/accum_32bit_pkg.sv
// Shared constants, state encodings, result payload and CLA helper functions
// for the accum_32bit block.
package accum_32bit_pkg;

  localparam int unsigned DATA_W        = 32;
  localparam int unsigned LEN_W_DEFAULT = 8;
  localparam int unsigned ST_W          = 2;

  // Control FSM state encodings
  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_ACCUM = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE  = 2'd2;

  // Accumulated result: running sum plus sticky carry/overflow flags
  typedef struct packed {
    logic [DATA_W-1:0] sum;
    logic              carry;
    logic              ovf;
  } accum_result_t;

  // Internal carries c1..c3 of a 4-wide lookahead cell (c0 is the cell carry-in)
  function automatic logic [2:0] cla_inner(input logic [3:0] g,
                                           input logic [3:0] p,
                                           input logic       c0);
    logic [2:0] c;
    c[0] = g[0] | (p[0] & c0);
    c[1] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    c[2] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c0);
    return c;
  endfunction

  // Group generate of a 4-wide cell
  function automatic logic grp_gen(input logic [3:0] g, input logic [3:0] p);
    return g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  endfunction

  // Group propagate of a 4-wide cell
  function automatic logic grp_prop(input logic [3:0] p);
    return &p;
  endfunction

endpackage

// File: rtl/accum_32bit_cla.sv
// 32-bit carry-lookahead adder: 4-bit cells, 4-cell super-groups, and a
// top-level lookahead across the two super-groups.
module cla_32bit
  import accum_32bit_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] sum,
  output logic              cout
);

  localparam int unsigned N_GRP = DATA_W / 4;
  localparam int unsigned N_SUP = N_GRP / 4;

  logic [DATA_W-1:0] g;
  logic [DATA_W-1:0] p;
  logic [DATA_W-1:0] c;
  logic [N_GRP-1:0]  gg1;
  logic [N_GRP-1:0]  pg1;
  logic [N_SUP-1:0]  gg2;
  logic [N_SUP-1:0]  pg2;
  logic [N_GRP-1:0]  cg;
  logic              c_mid;

  // Bit-level generate/propagate
  assign g = a & b;
  assign p = a ^ b;

  // Per-cell group terms and bit carries from each cell's carry-in
  for (genvar k = 0; k < int'(N_GRP); k++) begin : g_grp
    assign gg1[k]      = grp_gen(g[4*k +: 4], p[4*k +: 4]);
    assign pg1[k]      = grp_prop(p[4*k +: 4]);
    assign c[4*k +: 4] = {cla_inner(g[4*k +: 4], p[4*k +: 4], cg[k]), cg[k]};
  end

  // Super-group terms over four cells each
  for (genvar s = 0; s < int'(N_SUP); s++) begin : g_sup
    assign gg2[s] = grp_gen(gg1[4*s +: 4], pg1[4*s +: 4]);
    assign pg2[s] = grp_prop(pg1[4*s +: 4]);
  end

  // Top-level lookahead: carry into the upper super-group and final carry-out
  assign c_mid = gg2[0] | (pg2[0] & cin);
  assign cout  = gg2[1] | (pg2[1] & gg2[0]) | (pg2[1] & pg2[0] & cin);

  // Cell carry-ins inside each super-group
  assign cg = {cla_inner(gg1[7:4], pg1[7:4], c_mid), c_mid,
               cla_inner(gg1[3:0], pg1[3:0], cin),   cin};

  assign sum = p ^ c;

endmodule

// File: rtl/accum_32bit.sv
// Length-counted 32-bit accumulator with valid/ready operand input, a held
// result with sticky carry/overflow flags, and an IDLE/ACCUM/DONE controller.
module accum_32bit
  import accum_32bit_pkg::*;
#(
  parameter int unsigned LEN_W = LEN_W_DEFAULT
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_carry,
  output logic              out_ovf,
  output logic              busy
);

  logic [ST_W-1:0]   state;
  logic [ST_W-1:0]   state_n;
  logic [LEN_W-1:0]  count;
  logic [LEN_W-1:0]  count_n;
  accum_result_t     res;
  accum_result_t     res_n;
  logic              in_ready_n;
  logic              out_valid_n;
  logic              busy_n;
  logic [DATA_W-1:0] cla_sum;
  logic              cla_cout;
  logic              take;
  logic              ovf_step;

  // Datapath adder: running sum plus incoming operand
  cla_32bit u_cla (
    .a    (res.sum),
    .b    (in_data),
    .cin  (1'b0),
    .sum  (cla_sum),
    .cout (cla_cout)
  );

  // Operand handshake is qualified by the registered state only
  assign take     = in_valid && (state == ST_ACCUM);
  assign ovf_step = (res.sum[DATA_W-1] == in_data[DATA_W-1]) &&
                    (cla_sum[DATA_W-1] != res.sum[DATA_W-1]);

  // Next-state, count, result and registered-output decode
  always_comb begin
    state_n = state;
    count_n = count;
    res_n   = res;
    case (state)
      ST_IDLE: begin
        if (start) begin
          res_n   = '0;
          count_n = len;
          state_n = (len != '0) ? ST_ACCUM : ST_DONE;
        end
      end
      ST_ACCUM: begin
        if (take) begin
          res_n.sum   = cla_sum;
          res_n.carry = res.carry | cla_cout;
          res_n.ovf   = res.ovf | ovf_step;
          count_n     = count - LEN_W'(1);
          if (count == LEN_W'(1)) begin
            state_n = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    in_ready_n  = (state_n == ST_ACCUM);
    out_valid_n = (state_n == ST_DONE);
    busy_n      = (state_n != ST_IDLE);
  end

  // State, datapath and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      count     <= '0;
      res       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      res       <= res_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
      busy      <= busy_n;
    end
  end

  assign out_sum   = res.sum;
  assign out_carry = res.carry;
  assign out_ovf   = res.ovf;

endmodule

// File: tb/tb_accum_32bit.sv
// Self-checking bench for accum_32bit: directed corner jobs plus randomized
// jobs checked against an arithmetic reference model.
module tb_accum_32bit;

  localparam int unsigned LEN_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_sum;
  logic              out_carry;
  logic              out_ovf;
  logic              busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  logic [31:0] ops_q[$];
  logic [31:0] e_sum;
  logic        e_carry;
  logic        e_ovf;

  // Results captured by drive_job
  logic [31:0] r_sum;
  logic        r_carry;
  logic        r_ovf;
  logic        r_rdy_done;
  int          r_lat;
  bit          r_timeout;

  accum_32bit #(.LEN_W(LEN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .out_ovf   (out_ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: modular sum, unsigned carry via 33-bit add, overflow via wide signed add
  function automatic void model(input int n, output logic [31:0] s,
                                output logic c, output logic v);
    logic [32:0] t;
    longint      ss;
    s = '0; c = 1'b0; v = 1'b0;
    for (int i = 0; i < n; i++) begin
      t  = {1'b0, s} + {1'b0, ops_q[i]};
      ss = longint'($signed(s)) + longint'($signed(ops_q[i]));
      if (t[32]) c = 1'b1;
      if (ss > 64'sd2147483647 || ss < -64'sd2147483648) v = 1'b1;
      s = t[31:0];
    end
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drives one job from ops_q; captures outputs in DONE and result latency
  task automatic drive_job(input int n, input bit gaps, input bit handshake);
    int idx;
    int budget;
    int last_acc;
    bit acc_now;
    r_timeout = 1'b0;
    start = 1'b1; len = LEN_W'(n);
    last_acc = cyc;
    step();
    start = 1'b0;
    idx = 0; budget = 0;
    while (idx < n && budget < 4000) begin
      in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data  = in_valid ? ops_q[idx] : $urandom;
      acc_now  = in_valid && in_ready;
      if (acc_now) last_acc = cyc;
      step();
      if (acc_now) idx++;
      budget++;
    end
    in_valid = 1'b0; in_data = $urandom;
    if (idx < n) r_timeout = 1'b1;
    budget = 0;
    while (!out_valid && budget < 100) begin
      step();
      budget++;
    end
    if (!out_valid) r_timeout = 1'b1;
    r_lat = cyc - last_acc;
    r_sum = out_sum; r_carry = out_carry; r_ovf = out_ovf; r_rdy_done = in_ready;
    if (handshake) begin
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF;
    len = LEN_W'(3); out_ready = 1'b0;
    step(); step(); step();
    n_checks++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready got=%b exp=0", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b exp=0", out_valid); else n_pass++;
    n_checks++; if (out_sum !== 32'h0) $display("FAIL reset_out_sum got=%h exp=0", out_sum); else n_pass++;
    n_checks++; if (out_carry !== 1'b0) $display("FAIL reset_out_carry got=%b exp=0", out_carry); else n_pass++;
    n_checks++; if (out_ovf !== 1'b0) $display("FAIL reset_out_ovf got=%b exp=0", out_ovf); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", busy); else n_pass++;
    start = 1'b0; in_valid = 1'b0; rst_n = 1'b1;
    step();
    n_checks++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0)
      $display("FAIL post_reset_idle got busy=%b ov=%b rdy=%b exp=0,0,0", busy, out_valid, in_ready);
    else n_pass++;
  endtask

  // Directed arithmetic job: fixed operands and constant expected results
  task automatic test_directed(input string name, input int n,
                               input logic [31:0] x_sum, input logic x_c, input logic x_v);
    model(n, e_sum, e_carry, e_ovf);
    drive_job(n, 1'b0, 1'b1);
    n_checks++; if (r_lat !== 1) $display("FAIL %s_latency got=%0d exp=1", name, r_lat); else n_pass++;
    n_checks++; if (r_sum !== x_sum || r_sum !== e_sum) $display("FAIL %s_sum got=%h exp=%h", name, r_sum, x_sum); else n_pass++;
    n_checks++; if (r_carry !== x_c || r_carry !== e_carry) $display("FAIL %s_carry got=%b exp=%b", name, r_carry, x_c); else n_pass++;
    n_checks++; if (r_ovf !== x_v || r_ovf !== e_ovf) $display("FAIL %s_ovf got=%b exp=%b", name, r_ovf, x_v); else n_pass++;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0) $display("FAIL %s_release got ov=%b busy=%b exp=0,0", name, out_valid, busy); else n_pass++;
  endtask

  task automatic test_len_zero();
    ops_q.delete();
    drive_job(0, 1'b0, 1'b1);
    n_checks++; if (r_lat !== 1) $display("FAIL len0_latency got=%0d exp=1", r_lat); else n_pass++;
    n_checks++; if (r_sum !== 32'h0) $display("FAIL len0_sum got=%h exp=0", r_sum); else n_pass++;
    n_checks++; if (r_rdy_done !== 1'b0) $display("FAIL len0_in_ready got=%b exp=0", r_rdy_done); else n_pass++;
  endtask

  task automatic test_random();
    int n;
    for (int j = 0; j < 8; j++) begin
      n = $urandom_range(1, 9);
      ops_q.delete();
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(0, 3))
          0:       ops_q.push_back(32'h7FFF_FFFF - $urandom_range(0, 3));
          1:       ops_q.push_back(32'h8000_0000 | ($urandom & 32'hFF));
          default: ops_q.push_back($urandom);
        endcase
      end
      model(n, e_sum, e_carry, e_ovf);
      drive_job(n, 1'b1, 1'b1);
      n_checks++; if (r_timeout !== 1'b0) $display("FAIL rand%0d_timeout got=1 exp=0", j); else n_pass++;
      n_checks++; if (r_lat !== 1) $display("FAIL rand%0d_latency got=%0d exp=1", j, r_lat); else n_pass++;
      n_checks++; if ({r_sum, r_carry, r_ovf} !== {e_sum, e_carry, e_ovf})
        $display("FAIL rand%0d_result got=%h/%b/%b exp=%h/%b/%b", j, r_sum, r_carry, r_ovf, e_sum, e_carry, e_ovf);
      else n_pass++;
    end
  endtask

  task automatic test_max_len();
    ops_q.delete();
    for (int i = 0; i < 255; i++) ops_q.push_back($urandom);
    model(255, e_sum, e_carry, e_ovf);
    drive_job(255, 1'b0, 1'b1);
    n_checks++; if (r_lat !== 1) $display("FAIL maxlen_latency got=%0d exp=1", r_lat); else n_pass++;
    n_checks++; if ({r_sum, r_carry, r_ovf} !== {e_sum, e_carry, e_ovf})
      $display("FAIL maxlen_result got=%h/%b/%b exp=%h/%b/%b", r_sum, r_carry, r_ovf, e_sum, e_carry, e_ovf);
    else n_pass++;
  endtask

  // DONE held without out_ready while start and stray operands are presented
  task automatic test_hold_done();
    ops_q.delete(); ops_q.push_back(32'h1234_5678); ops_q.push_back(32'hF000_0001);
    model(2, e_sum, e_carry, e_ovf);
    drive_job(2, 1'b0, 1'b0);
    n_checks++; if (r_sum !== e_sum) $display("FAIL hold_sum got=%h exp=%h", r_sum, e_sum); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      start = (i % 2 == 0); len = LEN_W'(3); in_valid = 1'b1; in_data = $urandom;
      step();
      n_checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0 ||
          {out_sum, out_carry, out_ovf} !== {e_sum, e_carry, e_ovf})
        $display("FAIL hold_cycle%0d got ov=%b busy=%b rdy=%b res=%h/%b/%b exp 1,1,0 %h/%b/%b",
                 i, out_valid, busy, in_ready, out_sum, out_carry, out_ovf, e_sum, e_carry, e_ovf);
      else n_pass++;
    end
    in_valid = 1'b0;
    start = 1'b1; len = LEN_W'(0); out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    n_checks++; if (out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL handshake_start_ignored got ov=%b busy=%b exp=0,0", out_valid, busy);
    else n_pass++;
    step();
    start = 1'b0;
    n_checks++; if (out_valid !== 1'b1 || busy !== 1'b1 || out_sum !== 32'h0 || out_carry !== 1'b0 || out_ovf !== 1'b0)
      $display("FAIL back_to_back_start got ov=%b busy=%b sum=%h c=%b v=%b exp=1,1,0,0,0",
               out_valid, busy, out_sum, out_carry, out_ovf);
    else n_pass++;
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit seen_valid;
    start = 1'b1; len = LEN_W'(4);
    step();
    start = 1'b0; in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
    step();
    in_data = 32'h8000_0000;
    step();
    in_valid = 1'b0; rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    n_checks++; if ({in_ready, out_valid, out_sum, out_carry, out_ovf, busy} !== 37'h0)
      $display("FAIL midreset_outputs got rdy=%b ov=%b sum=%h c=%b v=%b busy=%b exp=all 0",
               in_ready, out_valid, out_sum, out_carry, out_ovf, busy);
    else n_pass++;
    seen_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (out_valid || busy) seen_valid = 1'b1;
    end
    n_checks++; if (seen_valid !== 1'b0) $display("FAIL midreset_job_discarded got=1 exp=0"); else n_pass++;
    ops_q.delete(); ops_q.push_back(32'd5);
    drive_job(1, 1'b0, 1'b1);
    n_checks++; if (r_sum !== 32'd5 || r_carry !== 1'b0 || r_ovf !== 1'b0)
      $display("FAIL midreset_fresh_job got=%h/%b/%b exp=00000005/0/0", r_sum, r_carry, r_ovf);
    else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    ops_q = '{32'd1, 32'd2, 32'd3};
    test_directed("basic", 3, 32'd6, 1'b0, 1'b0);
    ops_q = '{32'hFFFF_FFFF, 32'h0000_0002};
    test_directed("carry", 2, 32'h0000_0001, 1'b1, 1'b0);
    ops_q = '{32'h7FFF_FFFF, 32'h0000_0001};
    test_directed("ovf", 2, 32'h8000_0000, 1'b0, 1'b1);
    test_len_zero();
    test_random();
    test_max_len();
    test_hold_done();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/accum_32bit.md
ACCUM_32BIT -- requirements
Module: accum_32bit

Interface
REQ-001 SHALL have parameter LEN_W, default 8, giving the width of the operand-count input.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a new accumulation.
REQ-005 SHALL have port len  input  LEN_W  number of operands to sum; sampled only when start is accepted.
REQ-006 SHALL have port in_valid  input  1  operand on in_data is valid.
REQ-007 SHALL have port in_data  input  32  unsigned/two's-complement operand.
REQ-008 SHALL have port in_ready  output  1  block accepts an operand this cycle.
REQ-009 SHALL have port out_valid  output  1  result fields are valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the result.
REQ-011 SHALL have port out_sum  output  32  accumulated sum modulo 2^32.
REQ-012 SHALL have port out_carry  output  1  sticky: any unsigned carry-out occurred.
REQ-013 SHALL have port out_ovf  output  1  sticky: any signed overflow occurred.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement the FSM states IDLE, ACCUM, and DONE.
REQ-016 In IDLE, start=1 SHALL clear the accumulator, carry flag, and overflow flag, and load the remaining-count register with len.
REQ-017 From IDLE on start, the FSM SHALL go to ACCUM if len!=0, else to DONE.
REQ-018 start SHALL be ignored outside IDLE.
REQ-019 in_ready SHALL equal (state==ACCUM), a registered-state decode with no combinational path from in_valid.
REQ-020 An operand SHALL be accepted on a cycle where in_valid and in_ready are both 1.
REQ-021 On accept, the block SHALL update acc <= acc + in_data via the 32-bit CLA with cin=0, and decrement the remaining count.
REQ-022 On accept, carry |= cout and ovf |= (acc[31]==in_data[31]) && (sum[31]!=acc[31]).
REQ-023 The accept that brings the remaining count to 0 SHALL move the FSM to DONE; out_valid SHALL rise on the following cycle (latency 1 after the last accept).
REQ-024 In DONE, out_valid=1 and out_sum/out_carry/out_ovf SHALL hold stable until out_valid&&out_ready; the FSM SHALL then go to IDLE.
REQ-025 in_valid while not in ACCUM SHALL be ignored, with in_data not consumed.
REQ-026 in_valid may drop mid-ACCUM; the block SHALL then wait indefinitely with no timeout.
REQ-027 Sum overflow SHALL wrap modulo 2^32 without saturation.
REQ-028 start and out_ready asserted in the same DONE cycle SHALL complete the output handshake only; the start SHALL NOT be accepted.
REQ-029 Back-to-back jobs: the earliest next start SHALL be accepted the cycle after the handshake (in IDLE).
REQ-030 The maximum operands per job SHALL be 2^LEN_W-1.

Reset
REQ-031 While rst_n=0 at a clk edge, the block SHALL enter IDLE, with acc=0, count=0, carry=0, ovf=0.
REQ-032 Outputs during and after reset SHALL be: in_ready=0, out_valid=0, out_sum=0, out_carry=0, out_ovf=0, busy=0.
REQ-033 Reset mid-ACCUM or mid-DONE SHALL discard the job silently; no out_valid SHALL be produced for it.
REQ-034 Reset SHALL have no asynchronous path; rst_n changes affect state only at clk edges.

Structure
REQ-035 The state encodings (IDLE=2'd0, ACCUM=2'd1, DONE=2'd2) and the default LEN_W SHALL live in a shared defines/package file.
REQ-036 The adder SHALL be one instance of the existing cla_32bit sub-module; no behavioural '+' SHALL be used on the datapath.
REQ-037 The FSM, count, acc, and flags SHALL be held in registers; out_* SHALL be driven directly from registers.

Verification
REQ-038 Reset then start, len=3, operands 1,2,3 back-to-back -> out_valid one cycle after the 3rd accept; sum=6, carry=0, ovf=0.
REQ-039 len=2, operands 0xFFFFFFFF, 0x00000002 -> sum=0x00000001, carry=1, ovf=0.
REQ-040 len=2, operands 0x7FFFFFFF, 0x00000001 -> sum=0x80000000, carry=0, ovf=1.
REQ-041 len=0 start -> out_valid the next cycle; sum=0, no in_ready pulse.
REQ-042 Hold out_ready=0 for 5 cycles in DONE while pulsing start -> outputs stable, start ignored; the next job runs only after the handshake.
REQ-043 len=4, drop rst_n after 2 accepts -> IDLE and all outputs 0 next cycle; a fresh len=1 job with operand 5 -> sum=5.
